// File: rtl/cseq_pkg.sv
// Shared encodings for the control sequencer: FSM states, instruction field
// positions, opcode classes, branch condition codes and flag bit positions.
package cseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  localparam int OP1_HI  = 15;
  localparam int OP1_LO  = 14;
  localparam int OP2_HI  = 13;
  localparam int OP2_LO  = 11;
  localparam int COND_HI = 10;
  localparam int COND_LO = 8;
  localparam int OP3_HI  = 7;
  localparam int OP3_LO  = 4;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    OP1_ALU     = 2'b00,
    OP1_LDST    = 2'b01,
    OP1_BRANCH  = 2'b10,
    OP1_SPECIAL = 2'b11
  } op1_t;

  localparam logic [2:0] OP2_LOAD  = 3'b000;
  localparam logic [2:0] OP2_STORE = 3'b001;
  localparam logic [2:0] OP2_HALT  = 3'b111;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_Z  = 3'b001;
  localparam logic [2:0] COND_NZ = 3'b010;
  localparam logic [2:0] COND_N  = 3'b011;
  localparam logic [2:0] COND_NN = 3'b100;
  localparam logic [2:0] COND_C  = 3'b101;
  localparam logic [2:0] COND_V  = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

  // flags input is packed {V,C,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return signed'({{8{v[7]}}, v});
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a 3-bit condition code and the {V,C,N,Z}
// flags to a taken/not-taken decision. Purely combinational.
module cond_eval
  import cseq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags[FLAG_Z];
      COND_NZ: taken = ~flags[FLAG_Z];
      COND_N:  taken = flags[FLAG_N];
      COND_NN: taken = ~flags[FLAG_N];
      COND_C:  taken = flags[FLAG_C];
      COND_V:  taken = flags[FLAG_V];
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, ALU/memory handshakes, branch.
// Optional retired-instruction counter enabled by `define CONTROL_SEQUENCER_PERF_EN.
module control_sequencer
  import cseq_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [3:0]  flags,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic        halted,
  output logic        fault
`ifdef CONTROL_SEQUENCER_PERF_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  state_t                state;
  logic [15:0]           pc;
  logic [15:0]           ir;
  logic [WCW-1:0]        wait_cnt;
  op1_t                  op1;
  logic [2:0]            op2;
  logic [2:0]            cond;
  logic [3:0]            op3;
  logic signed [15:0]    br_off;
  logic [15:0]           pc_inc;
  logic [15:0]           pc_br;
  logic                  taken;
  logic                  wait_expired;
  logic                  is_mem_op;

  assign op1    = op1_t'(ir[OP1_HI:OP1_LO]);
  assign op2    = ir[OP2_HI:OP2_LO];
  assign cond   = ir[COND_HI:COND_LO];
  assign op3    = ir[OP3_HI:OP3_LO];
  assign br_off = sext8(ir[IMM_HI:IMM_LO]);

  // 16-bit adders wrap naturally, giving modulo-2^16 PC arithmetic
  assign pc_inc = pc + 16'd1;
  assign pc_br  = pc + $unsigned(br_off);

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign is_mem_op    = (op2 == OP2_LOAD) || (op2 == OP2_STORE);
  assign imem_addr    = pc;

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      wait_cnt  <= '0;
      imem_req  <= 1'b0;
      alu_op    <= '0;
      alu_start <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
      rf_we     <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      rf_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
            wait_cnt <= '0;
          end
        end

        S_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else if (wait_expired) begin
            imem_req <= 1'b0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        S_DECODE: begin
          case (op1)
            OP1_ALU: begin
              state     <= S_EXEC;
              alu_op    <= op3;
              alu_start <= 1'b1;
              wait_cnt  <= '0;
            end
            OP1_LDST: begin
              if (is_mem_op) begin
                state    <= S_MEM;
                dmem_req <= 1'b1;
                dmem_we  <= (op2 == OP2_STORE);
                wait_cnt <= '0;
              end else begin
                pc       <= pc_inc;
                state    <= S_FETCH;
                imem_req <= 1'b1;
                wait_cnt <= '0;
              end
            end
            OP1_BRANCH: begin
              pc       <= taken ? pc_br : pc_inc;
              state    <= S_FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end
            OP1_SPECIAL: begin
              if (op2 == OP2_HALT) begin
                halted <= 1'b1;
                state  <= S_HALT;
              end else begin
                pc       <= pc_inc;
                state    <= S_FETCH;
                imem_req <= 1'b1;
                wait_cnt <= '0;
              end
            end
            default: state <= S_FAULT;
          endcase
        end

        // alu_start still high marks the launch cycle, where alu_done is not yet valid
        S_EXEC: begin
          if (!alu_start && alu_done) begin
            alu_op <= '0;
            rf_we  <= 1'b1;
            state  <= S_WB;
          end else if (wait_expired) begin
            alu_op <= '0;
            fault  <= 1'b1;
            state  <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (op2 == OP2_LOAD) begin
              rf_we <= 1'b1;
              state <= S_WB;
            end else begin
              pc       <= pc_inc;
              state    <= S_FETCH;
              imem_req <= 1'b1;
              wait_cnt <= '0;
            end
          end else if (wait_expired) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            fault    <= 1'b1;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        S_WB: begin
          pc       <= pc_inc;
          state    <= S_FETCH;
          imem_req <= 1'b1;
          wait_cnt <= '0;
        end

        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_FAULT;
      endcase
    end
  end

`ifdef CONTROL_SEQUENCER_PERF_EN
  logic retire;

  // One pulse per instruction at the cycle it hands control back to FETCH
  always_comb begin
    retire = 1'b0;
    case (state)
      S_WB:     retire = 1'b1;
      S_MEM:    retire = dmem_ack && (op2 == OP2_STORE);
      S_DECODE: retire = (op1 == OP1_BRANCH) ||
                         ((op1 == OP1_LDST) && !is_mem_op) ||
                         ((op1 == OP1_SPECIAL) && (op2 != OP2_HALT));
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_control_sequencer;

  localparam int          WM  = 20;
  localparam logic [15:0] RPC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic        alu_done = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [3:0]  flags = '0;
  logic [15:0] imem_addr;
  logic        imem_req, alu_start, dmem_req, dmem_we, rf_we, halted, fault;
  logic [3:0]  alu_op;
`ifdef CONTROL_SEQUENCER_PERF_EN
  logic [31:0] retired_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] o_faddr;
  logic [3:0]  o_aop;
  int          o_astart, o_rf, o_dreq, o_we;
  bit          o_aop_stable, o_fhold, o_timeout;
  int          m_pc;

  control_sequencer #(.RESET_PC(RPC), .WAIT_MAX(WM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .alu_op    (alu_op),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .flags     (flags),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .halted    (halted),
    .fault     (fault)
`ifdef CONTROL_SEQUENCER_PERF_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: one instruction's architectural effect and handshake counts
  function automatic bit cond_true(input logic [2:0] c, input logic [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[1];
      3'd4: return !f[1];
      3'd5: return f[2];
      3'd6: return f[3];
      default: return 1'b0;
    endcase
  endfunction

  task automatic model(input int pc, input logic [15:0] w, input logic [3:0] f, input int rd,
                       output int npc, output int e_astart, output int e_rf,
                       output int e_dreq, output int e_we, output bit e_halt);
    int op1, op2;
    op1 = int'(w[15:14]);
    op2 = int'(w[13:11]);
    npc = (pc + 1) % 65536;
    e_astart = 0; e_rf = 0; e_dreq = 0; e_we = 0; e_halt = 1'b0;
    if (op1 == 0) begin
      e_astart = 1; e_rf = 1;
    end else if (op1 == 1) begin
      if (op2 == 0) begin e_dreq = rd + 1; e_rf = 1; end
      else if (op2 == 1) begin e_dreq = rd + 1; e_we = rd + 1; end
    end else if (op1 == 2) begin
      if (cond_true(w[10:8], f)) npc = (pc + int'($signed(w[7:0])) + 65536) % 65536;
    end else if (op2 == 7) begin
      e_halt = 1'b1; npc = pc;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Acts as instruction memory, ALU and data memory for one instruction; records what it saw
  task automatic run_instr(input logic [15:0] w, input logic [3:0] fl, input int fd, input int rd);
    int n, alu_t, mem_t;
    bit exec_on;
    o_astart = 0; o_rf = 0; o_dreq = 0; o_we = 0; o_aop = '0;
    o_aop_stable = 1'b1; o_fhold = 1'b1; o_timeout = 1'b0; o_faddr = 'x;
    n = 0;
    while (!imem_req && n < 40) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin o_timeout = 1'b1; return; end
    o_faddr = imem_addr;
    flags = fl;
    for (int i = 0; i < fd; i++) begin
      dmem_ack = 1'($urandom_range(0, 1));
      alu_done = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (!imem_req || imem_addr !== o_faddr) o_fhold = 1'b0;
    end
    dmem_ack = 1'b0; alu_done = 1'b0;
    imem_ack = 1'b1; imem_data = w;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    n = 0; exec_on = 1'b0; alu_t = -1; mem_t = -1;
    while (!(imem_req || halted || fault) && n < 60) begin
      if (rf_we) o_rf++;
      if (alu_start) begin
        o_astart++; o_aop = alu_op; exec_on = 1'b1; alu_t = n + rd;
      end else if (exec_on && alu_op !== o_aop) begin
        o_aop_stable = 1'b0;
      end
      if (dmem_req) begin
        o_dreq++;
        if (dmem_we) o_we++;
        if (mem_t < 0) mem_t = n + rd;
      end
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
      if (exec_on && !alu_start) alu_done = (n == alu_t);
      else alu_done = 1'($urandom_range(0, 1));
      if (dmem_req) dmem_ack = (n == mem_t);
      else dmem_ack = 1'($urandom_range(0, 1));
      if (exec_on && n == alu_t) exec_on = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    imem_ack = 1'b0; alu_done = 1'b0; dmem_ack = 1'b0;
    if (n >= 60) o_timeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; alu_done = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (imem_addr !== RPC) $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); else n_pass++;
    n_chk++; if ({imem_req, alu_start, dmem_req, dmem_we, rf_we, halted, fault} !== 7'b0)
      $display("FAIL reset_outs: got %b want 0", {imem_req, alu_start, dmem_req, dmem_we, rf_we, halted, fault}); else n_pass++;
    n_chk++; if (alu_op !== 4'h0) $display("FAIL reset_aluop: got %h want 0", alu_op); else n_pass++;
    rst_n = 1'b1;
    imem_ack = 1'b1;
    repeat (3) @(posedge clk); #1;
    imem_ack = 1'b0;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL idle_no_start: imem_req got %b want 0", imem_req); else n_pass++;
    m_pc = RPC;
  endtask

  task automatic test_alu();
    start = 1'b1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL start_cycle: imem_req got %b want 0", imem_req); else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    n_chk++; if (imem_req !== 1'b1) $display("FAIL fetch_after_start: imem_req got %b want 1", imem_req); else n_pass++;
    run_instr(16'h0050, 4'h0, 1, 3);
    n_chk++; if (o_faddr !== 16'h0000 || !o_fhold) $display("FAIL alu_fetch: addr %h hold %b want 0000 1", o_faddr, o_fhold); else n_pass++;
    n_chk++; if (o_aop !== 4'h5 || !o_aop_stable) $display("FAIL alu_op: got %h stable %b want 5 1", o_aop, o_aop_stable); else n_pass++;
    n_chk++; if (o_astart !== 1) $display("FAIL alu_start_pulses: got %0d want 1", o_astart); else n_pass++;
    n_chk++; if (o_rf !== 1) $display("FAIL alu_rf_we: got %0d want 1", o_rf); else n_pass++;
    n_chk++; if (imem_addr !== 16'h0001 || o_timeout) $display("FAIL alu_pc: got %h want 0001", imem_addr); else n_pass++;
    m_pc = 1;
  endtask

  task automatic test_branch();
    run_instr(16'h8004, 4'h0, 0, 1);
    n_chk++; if (imem_addr !== 16'h0005) $display("FAIL br_always: got %h want 0005", imem_addr); else n_pass++;
    run_instr(16'h8AFE, 4'b0000, 1, 1);
    n_chk++; if (imem_addr !== 16'h0003) $display("FAIL br_nz_taken: got %h want 0003", imem_addr); else n_pass++;
    run_instr(16'h8002, 4'b1111, 0, 1);
    n_chk++; if (imem_addr !== 16'h0005) $display("FAIL br_fwd: got %h want 0005", imem_addr); else n_pass++;
    run_instr(16'h8AFE, 4'b0001, 2, 1);
    n_chk++; if (imem_addr !== 16'h0006) $display("FAIL br_nz_not_taken: got %h want 0006", imem_addr); else n_pass++;
    n_chk++; if (o_rf !== 0 || o_astart !== 0 || o_dreq !== 0) $display("FAIL br_side_effects: rf %0d astart %0d dreq %0d want 0", o_rf, o_astart, o_dreq); else n_pass++;
  endtask

  task automatic test_store();
    run_instr(16'h4800, 4'h0, 0, 2);
    n_chk++; if (o_dreq !== 3) $display("FAIL st_dmem_req_cycles: got %0d want 3", o_dreq); else n_pass++;
    n_chk++; if (o_we !== 3) $display("FAIL st_dmem_we: got %0d want 3", o_we); else n_pass++;
    n_chk++; if (o_rf !== 0) $display("FAIL st_rf_we: got %0d want 0", o_rf); else n_pass++;
    n_chk++; if (imem_addr !== 16'h0007) $display("FAIL st_pc: got %h want 0007", imem_addr); else n_pass++;
  endtask

  task automatic test_halt_wrap();
    run_instr(16'h80F8, 4'h0, 0, 1);
    n_chk++; if (imem_addr !== 16'hFFFF) $display("FAIL br_to_ffff: got %h want ffff", imem_addr); else n_pass++;
    run_instr(16'hC000, 4'h0, 0, 1);
    n_chk++; if (imem_addr !== 16'h0000) $display("FAIL nop_wrap: got %h want 0000", imem_addr); else n_pass++;
    run_instr(16'h80FF, 4'h0, 0, 1);
    run_instr(16'hF800, 4'h0, 1, 1);
    n_chk++; if (halted !== 1'b1 || fault !== 1'b0) $display("FAIL halt_flag: halted %b fault %b want 1 0", halted, fault); else n_pass++;
    n_chk++; if (imem_addr !== 16'hFFFF) $display("FAIL halt_pc: got %h want ffff", imem_addr); else n_pass++;
    start = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; alu_done = 1'b1;
    repeat (4) @(posedge clk); #1;
    start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_done = 1'b0;
    n_chk++; if (halted !== 1'b1 || {imem_req, dmem_req, alu_start, rf_we} !== 4'b0 || imem_addr !== 16'hFFFF)
      $display("FAIL halt_terminal: halted %b reqs %b addr %h want 1 0000 ffff", halted, {imem_req, dmem_req, alu_start, rf_we}, imem_addr); else n_pass++;
  endtask

  task automatic test_timeout();
    int cnt, n;
    do_reset();
    pulse_start();
    cnt = 0; n = 0;
    while (!fault && n < 4 * WM) begin
      if (imem_req) cnt++;
      @(posedge clk); #1;
      n++;
    end
    n_chk++; if (fault !== 1'b1) $display("FAIL to_fault: got %b want 1", fault); else n_pass++;
    n_chk++; if (cnt !== WM) $display("FAIL to_wait_cycles: got %0d want %0d", cnt, WM); else n_pass++;
    n_chk++; if (imem_req !== 1'b0 || halted !== 1'b0) $display("FAIL to_outputs: imem_req %b halted %b want 0 0", imem_req, halted); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    pulse_start();
    run_instr(16'h8010, 4'h0, 0, 1);
    n_chk++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) $display("FAIL pre_reset_fetch: addr %h req %b want 0010 1", imem_addr, imem_req); else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (imem_req !== 1'b0 || imem_addr !== RPC) $display("FAIL async_reset: req %b addr %h want 0 %h", imem_req, imem_addr, RPC); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL post_reset_idle: imem_req got %b want 0", imem_req); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [3:0]  f;
    int fd, rd, npc, e_astart, e_rf, e_dreq, e_we;
    bit e_halt;
    do_reset();
    pulse_start();
    m_pc = RPC;
    for (int k = 0; k < 60; k++) begin
      w  = 16'($urandom);
      if (w[15:14] == 2'b11 && w[13:11] == 3'b111) w[13:11] = 3'b000;
      f  = 4'($urandom);
      fd = int'($urandom_range(0, 3));
      rd = int'($urandom_range(1, 4));
      model(m_pc, w, f, rd, npc, e_astart, e_rf, e_dreq, e_we, e_halt);
      run_instr(w, f, fd, rd);
      n_chk++; if (o_timeout || o_faddr !== 16'(m_pc) || !o_fhold)
        $display("FAIL rnd%0d_fetch: addr %h hold %b timeout %b want %h 1 0", k, o_faddr, o_fhold, o_timeout, 16'(m_pc)); else n_pass++;
      n_chk++; if (imem_addr !== 16'(npc)) $display("FAIL rnd%0d_pc w=%h f=%b: got %h want %h", k, w, f, imem_addr, 16'(npc)); else n_pass++;
      n_chk++; if (o_rf !== e_rf || o_astart !== e_astart)
        $display("FAIL rnd%0d_strobes w=%h: rf %0d astart %0d want %0d %0d", k, w, o_rf, o_astart, e_rf, e_astart); else n_pass++;
      n_chk++; if (o_dreq !== e_dreq || o_we !== e_we)
        $display("FAIL rnd%0d_dmem w=%h: req %0d we %0d want %0d %0d", k, w, o_dreq, o_we, e_dreq, e_we); else n_pass++;
      if (e_astart == 1) begin
        n_chk++; if (o_aop !== w[7:4] || !o_aop_stable)
          $display("FAIL rnd%0d_aluop: got %h stable %b want %h 1", k, o_aop, o_aop_stable, w[7:4]); else n_pass++;
      end
      m_pc = npc;
    end
    w = 16'hF800;
    model(m_pc, w, 4'h0, 1, npc, e_astart, e_rf, e_dreq, e_we, e_halt);
    run_instr(w, 4'h0, 0, 1);
    n_chk++; if (halted !== e_halt || imem_addr !== 16'(npc))
      $display("FAIL rnd_halt: halted %b addr %h want %b %h", halted, imem_addr, e_halt, 16'(npc)); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_halt_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
